// File: rtl/muldiv_iter_if.sv
// -----------------------------------------------------------------------------
// muldiv_iter_if
//   Request/response bundle for the iterative multiply/divide unit.
//   master : the EXE-stage issuer (drives request and control, reads result)
//   slave  : the muldiv_iter unit
// Signals:
//   start, op_mul, is_signed, a, b : operation request, sampled in IDLE
//   annul                          : abandon the current operation
//   hold                           : consumer stalled, keep result presented
//   busy, ready, hi, lo            : status and HI/LO result pair
//   div_by_zero                    : presented result came from a divide by 0
// -----------------------------------------------------------------------------
interface muldiv_iter_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op_mul;
  logic             is_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             annul;
  logic             hold;
  logic             busy;
  logic             ready;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;

  modport master (
    output start, op_mul, is_signed, a, b, annul, hold,
    input  busy, ready, hi, lo, div_by_zero
  );

  modport slave (
    input  start, op_mul, is_signed, a, b, annul, hold,
    output busy, ready, hi, lo, div_by_zero
  );
endinterface

// File: rtl/muldiv_iter.sv
// -----------------------------------------------------------------------------
// muldiv_iter
//   Iterative signed/unsigned multiply and divide sharing one shift datapath.
//   One result bit per cycle; results are returned as a HI/LO pair.
//   Divide   : restoring, on operand magnitudes; lo = quotient, hi = remainder.
//   Multiply : shift-add, on operand magnitudes; {hi,lo} = product.
//   Signs are applied once, on the CALC -> DONE transition.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : muldiv_iter_if slave modport (request, control, result)
// -----------------------------------------------------------------------------
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_iter_if.slave  bus
);

  localparam int              CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             op_mul_q;
  logic             sa_q;
  logic             sb_q;
  // mag_q holds |b| for divide (divisor) and |a| for multiply (addend);
  // acc_lo_q holds the dividend/quotient or the multiplier/product-low bits.
  logic [WIDTH-1:0] mag_q;
  logic [WIDTH-1:0] acc_hi_q;
  logic [WIDTH-1:0] acc_lo_q;
  logic             busy_q;
  logic             ready_q;
  logic             dbz_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  // Operand capture helpers
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  // One datapath step and the sign-fixed final result
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     trial;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   step_hi_d;
  logic [WIDTH-1:0]   step_lo_d;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   res_hi_d;
  logic [WIDTH-1:0]   res_lo_d;

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    a_neg     = bus.is_signed & bus.a[WIDTH-1];
    b_neg     = bus.is_signed & bus.b[WIDTH-1];
    a_mag     = a_neg ? -bus.a : bus.a;
    b_mag     = b_neg ? -bus.b : bus.b;

    shifted   = '0;
    trial     = '0;
    sum       = '0;
    step_hi_d = acc_hi_q;
    step_lo_d = acc_lo_q;

    if (op_mul_q) begin
      // Add the multiplicand into the upper half (with carry), then shift
      // the whole accumulator right so the next multiplier bit lands in bit 0.
      sum       = acc_lo_q[0] ? ({1'b0, acc_hi_q} + {1'b0, mag_q})
                              : {1'b0, acc_hi_q};
      step_hi_d = sum[WIDTH:1];
      step_lo_d = {sum[0], acc_lo_q[WIDTH-1:1]};
    end else begin
      // Shift {rem,quo} left and trial-subtract the divisor from the upper
      // WIDTH+1 bits; a clear borrow means the quotient bit is 1.
      shifted = {acc_hi_q, acc_lo_q[WIDTH-1]};
      trial   = shifted - {1'b0, mag_q};
      if (!trial[WIDTH]) begin
        step_hi_d = trial[WIDTH-1:0];
        step_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
      end else begin
        step_hi_d = shifted[WIDTH-1:0];
        step_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
      end
    end

    prod = {step_hi_d, step_lo_d};
    if (op_mul_q) begin
      if (sa_q ^ sb_q) prod = -prod;
      res_hi_d = prod[2*WIDTH-1:WIDTH];
      res_lo_d = prod[WIDTH-1:0];
    end else begin
      // Remainder follows the dividend's sign; MIN / -1 wraps back to MIN.
      res_lo_d = (sa_q ^ sb_q) ? -step_lo_d : step_lo_d;
      res_hi_d = sa_q ? -step_hi_d : step_hi_d;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register in
  // this block samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_mul_q <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      mag_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
      dbz_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else if (bus.annul) begin
      // Annul wins over a coincident start or completion; hi/lo keep value.
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            op_mul_q <= bus.op_mul;
            sa_q     <= a_neg;
            sb_q     <= b_neg;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            dbz_q    <= 1'b0;
            if (!bus.op_mul && (bus.b == '0)) begin
              // Divide by zero resolves at once with the fixed result.
              state_q <= S_DONE;
              ready_q <= 1'b1;
              dbz_q   <= 1'b1;
              hi_q    <= bus.a;
              lo_q    <= '1;
            end else begin
              state_q  <= S_CALC;
              acc_hi_q <= '0;
              acc_lo_q <= bus.op_mul ? b_mag : a_mag;
              mag_q    <= bus.op_mul ? a_mag : b_mag;
            end
          end
        end
        S_CALC: begin
          acc_hi_q <= step_hi_d;
          acc_lo_q <= step_lo_d;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST) begin
            state_q <= S_DONE;
            ready_q <= 1'b1;
            hi_q    <= res_hi_d;
            lo_q    <= res_lo_d;
          end
        end
        S_DONE: begin
          if (!bus.hold) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.ready       = ready_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.div_by_zero = dbz_q;

endmodule
